// File: rtl/byte_serializer.sv
// byte_serializer: parallel-in MSB-first serial transmitter with frame/done strobes; `define SERIALIZER_PARITY_EN appends an even-parity bit
module byte_serializer #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk_100M,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              ser_out,
  output logic              ser_en,
  output logic              frame,
  output logic              busy,
  output logic              done
);
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif
  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic              ser_out_q, ser_out_d;
  logic              ser_en_q, ser_en_d;
  logic              frame_q, frame_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wrap;
`ifdef SERIALIZER_PARITY_EN
  logic              par_q, par_d;
`endif
  assign load_ready = state_q == IDLE;
  assign ser_out    = ser_out_q;
  assign ser_en     = ser_en_q;
  assign frame      = frame_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign wrap       = phase_q == PH_LAST;
  // next state, then outputs decoded from the state being entered so they register in step with it
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    phase_d = phase_q;
`ifdef SERIALIZER_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: if (load_valid) begin
        state_d = SHIFT;
        shift_d = data_in;
        bit_d   = '0;
        phase_d = '0;
`ifdef SERIALIZER_PARITY_EN
        par_d   = ^data_in;
`endif
      end
      SHIFT: begin
        phase_d = wrap ? '0 : phase_q + 1'b1;
        if (wrap) begin
          shift_d = {shift_q[DATA_W-2:0], 1'b0};
          bit_d   = bit_q + 1'b1;
`ifdef SERIALIZER_PARITY_EN
          if (bit_q == BIT_LAST) state_d = PARITY;
`else
          if (bit_q == BIT_LAST) state_d = DONE;
`endif
        end
      end
`ifdef SERIALIZER_PARITY_EN
      PARITY: begin
        phase_d = wrap ? '0 : phase_q + 1'b1;
        if (wrap) state_d = DONE;
      end
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef SERIALIZER_PARITY_EN
    ser_out_d = (state_d == PARITY) ? par_d : (state_d == SHIFT) & shift_d[DATA_W-1];
    frame_d   = state_d == SHIFT || state_d == PARITY;
`else
    ser_out_d = (state_d == SHIFT) & shift_d[DATA_W-1];
    frame_d   = state_d == SHIFT;
`endif
    ser_en_d = frame_d && phase_d == '0;
    busy_d   = state_d != IDLE;
    done_d   = state_d == DONE;
  end
  // state, datapath and registered outputs; reset aborts any word in flight
  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_q     <= '0;
      phase_q   <= '0;
      ser_out_q <= 1'b0;
      ser_en_q  <= 1'b0;
      frame_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_q     <= bit_d;
      phase_q   <= phase_d;
      ser_out_q <= ser_out_d;
      ser_en_q  <= ser_en_d;
      frame_q   <= frame_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end
`ifdef SERIALIZER_PARITY_EN
  // parity of the word as latched at the handshake
  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) par_q <= 1'b0;
    else par_q <= par_d;
  end
`endif
endmodule

// File: tb/tb_byte_serializer.sv
// tb_byte_serializer: directed checks of framing, timing, busy-ignore, reset abort and CLK_DIV=1
module tb_byte_serializer;
  logic       clk_100M = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = '0, data_in_b = '0;
  logic       load_valid = 1'b0, load_valid_b = 1'b0;
  logic       load_ready, ser_out, ser_en, frame, busy, done;
  logic       load_ready_b, ser_out_b, ser_en_b, frame_b, busy_b, done_b;
  logic [5:0] obs_a, obs_b;
  int         n = 0;
  int         fails = 0;
  always #5 clk_100M = ~clk_100M;
  byte_serializer #(.DATA_W(8), .CLK_DIV(4)) dut_a (
    .clk_100M(clk_100M), .rst(rst), .data_in(data_in), .load_valid(load_valid),
    .load_ready(load_ready), .ser_out(ser_out), .ser_en(ser_en), .frame(frame),
    .busy(busy), .done(done)
  );
  byte_serializer #(.DATA_W(8), .CLK_DIV(1)) dut_b (
    .clk_100M(clk_100M), .rst(rst), .data_in(data_in_b), .load_valid(load_valid_b),
    .load_ready(load_ready_b), .ser_out(ser_out_b), .ser_en(ser_en_b), .frame(frame_b),
    .busy(busy_b), .done(done_b)
  );
  assign obs_a = {load_ready, ser_out, ser_en, frame, busy, done};
  assign obs_b = {load_ready_b, ser_out_b, ser_en_b, frame_b, busy_b, done_b};
  task automatic tick();
    @(posedge clk_100M);
    #1;
  endtask
  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s at %0t: observed {rdy,ser,en,frm,bsy,dn}=%b expected=%b", tag, $time, obs, exp);
    end
  endtask
  task automatic frame_bits(input logic [7:0] w);
    for (int i = 0; i < 32; i++) begin
      if (i != 0) tick();
      chk("a_bit", obs_a, {1'b0, w[3'(7 - i / 4)], i % 4 == 0, 3'b110});
    end
`ifdef SERIALIZER_PARITY_EN
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("a_par", obs_a, {1'b0, ^w, i == 0, 3'b110});
    end
`endif
    tick();
    chk("a_done", obs_a, 6'b000011);
  endtask
  initial begin
    #1;
    chk("rst_a0", obs_a, 6'b100000);
    chk("rst_b0", obs_b, 6'b100000);
    #60;
    chk("rst_a1", obs_a, 6'b100000);
    #70;
    chk("rst_a2", obs_a, 6'b100000);
    #1 rst = 1'b0;
    tick();
    chk("idle_a", obs_a, 6'b100000);
    tick();
    chk("idle_hold", obs_a, 6'b100000);
    data_in = 8'hA5;
    load_valid = 1'b1;
    tick();
    data_in = 8'h00;
    frame_bits(8'hA5);
    load_valid = 1'b0;
    tick();
    chk("a5_ready", obs_a, 6'b100000);
    tick();
    chk("a5_idle", obs_a, 6'b100000);
    data_in = 8'h3C;
    load_valid = 1'b1;
    tick();
    data_in = 8'hFF;
    frame_bits(8'h3C);
    tick();
    chk("b2b_gap", obs_a, 6'b100000);
    tick();
    load_valid = 1'b0;
    frame_bits(8'hFF);
    tick();
    chk("ff_ready", obs_a, 6'b100000);
    data_in = 8'hC3;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (i != 0) tick();
      chk("c3_bit", obs_a, {1'b0, data_in[3'(7 - i / 4)], i % 4 == 0, 3'b110});
    end
    #2 rst = 1'b1;
    #1;
    chk("abort_now", obs_a, 6'b100000);
    tick();
    chk("abort_hold", obs_a, 6'b100000);
    tick();
    chk("abort_nodone", obs_a, 6'b100000);
    #3 rst = 1'b0;
    tick();
    chk("abort_idle", obs_a, 6'b100000);
    data_in = 8'h81;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    frame_bits(8'h81);
    tick();
    chk("81_ready", obs_a, 6'b100000);
    data_in_b = 8'h07;
    load_valid_b = 1'b1;
    tick();
    load_valid_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) tick();
      chk("b_bit", obs_b, {1'b0, data_in_b[3'(7 - i)], 4'b1110});
    end
`ifdef SERIALIZER_PARITY_EN
    tick();
    chk("b_par", obs_b, 6'b011110);
`endif
    tick();
    chk("b_done", obs_b, 6'b000011);
    tick();
    chk("b_ready", obs_b, 6'b100000);
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
